jtag_scan_display: RTL and testbench
====================================

# jtag_scan_display

Parametrised boundary-scannable multi-digit 7-segment display with its own on-chip IEEE 1149.1-style TAP controller. It holds a 4*DIGITS-bit value loaded in parallel and decodes each nibble to a segment pattern. It exposes one boundary register covering every digit input and segment output, plus instruction, bypass and IDCODE registers, all behind a single TDI/TDO port. It replaces per-digit scan chains in the display path of the JTAG test designs. JTAG pins are sampled on the system clock, so the block is fully single-clock.

## Interface
Parameters:
- DIGITS, 2: number of 7-seg digits; data width 4*DIGITS; boundary length 11*DIGITS.
- IDCODE, 32'h1234_5001: value shifted out in IDCODE; bit 0 must be 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; one clock, one reset.
- TCK  in  1  JTAG clock, sampled by clk as data, never used as a clock.
- TMS  in  1  JTAG mode select, sampled.
- TDI  in  1  JTAG serial in, sampled.
- TRST  in  1  active-low TAP reset, sampled, acts synchronously.
- load  in  1  captures d_in into the hold register.
- d_in  in  4*DIGITS  parallel display value; digit k = d_in[4k+3:4k].
- y  out  7*DIGITS  segments, active-high, {g,f,e,d,c,b,a} per digit; digit k = y[7k+6:7k].
- TDO  out  1  JTAG serial out.
- tdo_oe  out  1  high while the TAP is in Shift-IR or Shift-DR.

## Operation
- TCK, TMS, TDI and TRST each pass through 2-flop synchronisers.
- tck_rise / tck_fall are 1-cycle pulses decoded from the synchronised TCK and its previous value.
- TAP FSM: the full 16-state 1149.1 graph.
  - It advances only on tck_rise, using synchronised TMS.
  - It enters Test-Logic-Reset on reset, when synchronised TRST=0, or after 5 consecutive tck_rise with TMS=1.
- IR is 2 bits. Opcodes: 00 EXTEST, 01 SAMPLE, 10 IDCODE, 11 BYPASS.
  - Capture-IR loads 2'b01.
  - Update-IR transfers the shift stage to the active IR.
  - Test-Logic-Reset forces the active IR to IDCODE.
- DR selected by active IR:
  - EXTEST / SAMPLE → boundary register.
  - IDCODE → 32-bit ID register.
  - BYPASS → 1-bit register that captures 0.
- Boundary cells for digit k:
  - bits [11k+3:11k] are input cells, capturing the hold-register nibble.
  - bits [11k+10:11k+4] are output cells, capturing the decoder output.
- Shift moves bits toward TDO. Bit 0 leaves first; TDI enters the MSB.
- In Shift states the register selected by IR shifts on each tck_rise. Capture and Update also act on tck_rise, in Capture-xR and Update-xR.
- Update-DR with EXTEST or SAMPLE copies boundary bits into a parallel update latch.
- Output mux:
  - Active IR = EXTEST: y = update-latch output cells.
  - Any other IR: y = decode(hold register).
  - Input cells never override the hold register.
- Hold register: load=1 → hold ≤ d_in. This works independently of the TAP in every state.
- Decoder table, hex 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.

## Timing
- Reset values:
  - TAP in Test-Logic-Reset; IR = IDCODE.
  - Hold register, boundary, update latch and bypass all 0.
  - y = {DIGITS{7'h3F}}; TDO=0; tdo_oe=0.
- tck_rise is asserted 3 clk after the TCK pin rises. TMS and TDI go through the same synchroniser depth, so their timing relative to TCK is preserved.
- TCK high and low phases must each be at least 4 clk cycles. Shorter pulses are unsupported and may be lost.
- On tck_fall, TDO registers the LSB of the selected shift register; it holds 0 outside Shift states.
- tdo_oe changes on that same clk edge.
- load → y updates 1 clk later, when IR is not EXTEST.
- Update-DR in EXTEST → y changes 1 clk after the update tck_rise.
- load and Update-DR in the same cycle: both take effect. In EXTEST, y follows the latch.
- TRST low or reset mid-shift: partial shift is discarded, IR = IDCODE and EXTEST drive is released on the next clk. The hold register is cleared only by reset, not by TRST.

## Structure
- Package jtag_pkg holds:
  - tap_state_t enum, 16 states;
  - the IR opcode localparams;
  - function seg7_decode(logic [3:0]) returning logic [6:0].
- Sub-module jtag_tap_ctrl holds the synchronisers, edge detect and TAP FSM. It outputs tck_rise, tck_fall, the state, and the tdi/tms sample.
- The top holds the IR, the DRs, the hold register, the update latch and the output mux.

## Test plan
- reset; TMS 0,1,0,0 → Shift-DR; 32 TCKs → TDO stream LSB-first = 32'h1234_5001, tdo_oe=1 during shift only.
- DIGITS=2: load d_in=8'h3A; IR ← 01 (SAMPLE); capture and shift 22 bits → bits[3:0]=A, [10:4]=77, [14:11]=3, [21:15]=4F.
- IR ← 00 (EXTEST); shift 22'h3F_FFFF; Update-DR → y = 14'h3FFF. Then load d_in=8'h00 → y stays 14'h3FFF until IR changes.
- IR ← 11 (BYPASS); shift TDI 1,0,1,1 → TDO 0,1,0,1, delayed one TCK.
- In EXTEST mid Shift-DR, TRST low 1 clk → TAP in Test-Logic-Reset, IR=IDCODE, y back to decode(hold).
- TMS=1 for 5 TCKs from Pause-DR → Test-Logic-Reset.
- Assert reset while load=1 → y = 14'h1FBF ({3F,3F}) next clk.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared types for the scan-display slice: TAP states, IR opcodes and
// the hex-to-7-segment decoder.
package jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_t;

    localparam logic [1:0] IR_EXTEST = 2'b00;
    localparam logic [1:0] IR_SAMPLE = 2'b01;
    localparam logic [1:0] IR_IDCODE = 2'b10;
    localparam logic [1:0] IR_BYPASS = 2'b11;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg7_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/jtag_tap_ctrl.sv
// JTAG pin synchronisers, TCK edge detection and the 16-state TAP FSM,
// all running on the system clock.
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tck,
    input  logic       tms,
    input  logic       tdi,
    input  logic       trst_n,
    output logic       tck_rise,
    output logic       tck_fall,
    output logic       tdi_s,
    output logic       tap_reset,
    output tap_state_t state
);

    logic [1:0] tck_sync;
    logic [1:0] tms_sync;
    logic [1:0] tdi_sync;
    logic [1:0] trst_sync;
    logic       tck_prev;
    logic       tms_s;
    tap_state_t state_next;

    // Edge pulses and the TMS/TDI samples are registered together so they
    // stay aligned with each other three clocks after the pins move.
    always_ff @(posedge clk) begin
        if (reset) begin
            tck_sync  <= 2'b00;
            tms_sync  <= 2'b11;
            tdi_sync  <= 2'b00;
            trst_sync <= 2'b11;
            tck_prev  <= 1'b0;
            tck_rise  <= 1'b0;
            tck_fall  <= 1'b0;
            tms_s     <= 1'b1;
            tdi_s     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], tck};
            tms_sync  <= {tms_sync[0], tms};
            tdi_sync  <= {tdi_sync[0], tdi};
            trst_sync <= {trst_sync[0], trst_n};
            tck_prev  <= tck_sync[1];
            tck_rise  <= tck_sync[1] & ~tck_prev;
            tck_fall  <= ~tck_sync[1] & tck_prev;
            tms_s     <= tms_sync[1];
            tdi_s     <= tdi_sync[1];
        end
    end

    assign tap_reset = ~trst_sync[1];

    always_ff @(posedge clk) begin
        if (reset || tap_reset) begin
            state <= TAP_TLR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (tck_rise) begin
            case (state)
                TAP_TLR:      state_next = tms_s ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state_next = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state_next = tms_s ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_next = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_next = tms_s ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_next = tms_s ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_next = tms_s ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_next = tms_s ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_next = tms_s ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state_next = tms_s ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state_next = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_next = tms_s ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_next = tms_s ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_next = tms_s ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_next = tms_s ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_next = tms_s ? TAP_SEL_DR   : TAP_RTI;
                default:      state_next = TAP_TLR;
            endcase
        end
    end

endmodule

// File: rtl/jtag_scan_display.sv
// Multi-digit 7-segment display with a boundary register, IDCODE and
// bypass behind an on-chip TAP controller.
module jtag_scan_display
    import jtag_pkg::*;
#(
    parameter int          DIGITS = 2,
    parameter logic [31:0] IDCODE = 32'h1234_5001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  TCK,
    input  logic                  TMS,
    input  logic                  TDI,
    input  logic                  TRST,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d_in,
    output logic [7*DIGITS-1:0]   y,
    output logic                  TDO,
    output logic                  tdo_oe
);

    localparam int BSR_LEN = 11 * DIGITS;

    logic                  tck_rise;
    logic                  tck_fall;
    logic                  tdi_s;
    logic                  tap_reset;
    tap_state_t            state;

    logic [4*DIGITS-1:0]   hold;
    logic [1:0]            ir_shift;
    logic [1:0]            ir_active;
    logic [BSR_LEN-1:0]    bsr;
    logic [BSR_LEN-1:0]    bsr_upd;
    logic [BSR_LEN-1:0]    bsr_cap;
    logic [31:0]           id_sr;
    logic                  bypass_sr;
    logic [7*DIGITS-1:0]   dec_y;
    logic [7*DIGITS-1:0]   latch_y;
    logic                  dr_lsb;
    logic                  bsr_selected;

    jtag_tap_ctrl u_tap (
        .clk       (clk),
        .reset     (reset),
        .tck       (TCK),
        .tms       (TMS),
        .tdi       (TDI),
        .trst_n    (TRST),
        .tck_rise  (tck_rise),
        .tck_fall  (tck_fall),
        .tdi_s     (tdi_s),
        .tap_reset (tap_reset),
        .state     (state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hold <= '0;
        end else if (load) begin
            hold <= d_in;
        end
    end

    // Per digit: 4 input cells (hold nibble) below 7 output cells (segments).
    always_comb begin
        dec_y   = '0;
        latch_y = '0;
        bsr_cap = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dec_y[7*k +: 7]      = seg7_decode(hold[4*k +: 4]);
            bsr_cap[11*k +: 4]   = hold[4*k +: 4];
            bsr_cap[11*k+4 +: 7] = seg7_decode(hold[4*k +: 4]);
            latch_y[7*k +: 7]    = bsr_upd[11*k+4 +: 7];
        end
    end

    assign bsr_selected = (ir_active == IR_EXTEST) || (ir_active == IR_SAMPLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_shift  <= '0;
            ir_active <= IR_IDCODE;
            bsr       <= '0;
            bsr_upd   <= '0;
            id_sr     <= '0;
            bypass_sr <= 1'b0;
        end else if (tap_reset || state == TAP_TLR) begin
            // Any partial scan is dropped; the update latch keeps its value
            // but no longer drives y once IR leaves EXTEST.
            ir_shift  <= '0;
            ir_active <= IR_IDCODE;
            bsr       <= '0;
            id_sr     <= '0;
            bypass_sr <= 1'b0;
        end else if (tck_rise) begin
            case (state)
                TAP_CAP_IR:   ir_shift  <= 2'b01;
                TAP_SHIFT_IR: ir_shift  <= {tdi_s, ir_shift[1]};
                TAP_UPD_IR:   ir_active <= ir_shift;
                TAP_CAP_DR: begin
                    if (bsr_selected)                 bsr       <= bsr_cap;
                    else if (ir_active == IR_IDCODE)  id_sr     <= IDCODE;
                    else                              bypass_sr <= 1'b0;
                end
                TAP_SHIFT_DR: begin
                    if (bsr_selected)                 bsr       <= {tdi_s, bsr[BSR_LEN-1:1]};
                    else if (ir_active == IR_IDCODE)  id_sr     <= {tdi_s, id_sr[31:1]};
                    else                              bypass_sr <= tdi_s;
                end
                TAP_UPD_DR: begin
                    if (bsr_selected) bsr_upd <= bsr;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (bsr_selected)                dr_lsb = bsr[0];
        else if (ir_active == IR_IDCODE) dr_lsb = id_sr[0];
        else                             dr_lsb = bypass_sr;
    end

    always_ff @(posedge clk) begin
        if (reset || tap_reset) begin
            TDO    <= 1'b0;
            tdo_oe <= 1'b0;
        end else if (tck_fall) begin
            tdo_oe <= (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);
            if (state == TAP_SHIFT_IR)      TDO <= ir_shift[0];
            else if (state == TAP_SHIFT_DR) TDO <= dr_lsb;
            else                            TDO <= 1'b0;
        end
    end

    assign y = (ir_active == IR_EXTEST) ? latch_y : dec_y;

endmodule

// File: tb/tb_jtag_scan_display.sv
// Self-checking bench for jtag_scan_display (DIGITS=2): TCK-level reference
// model plus literal checks of the directed scan scenarios.
module tb_jtag_scan_display;

    localparam int BL = 22;

    localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4,
                   T_E1DR = 5, T_PDR = 6, T_E2DR = 7, T_UDR = 8,
                   T_SIR = 9, T_CIR = 10, T_SHIR = 11, T_E1IR = 12,
                   T_PIR = 13, T_E2IR = 14, T_UIR = 15;

    logic        clk = 1'b0;
    logic        reset, TCK, TMS, TDI, TRST, load;
    logic [7:0]  d_in;
    logic [13:0] y;
    logic        TDO, tdo_oe;

    int n_checks = 0;
    int n_fail   = 0;
    bit valid    = 0;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_state;
    logic [1:0]  m_ir, m_irsh;
    logic [31:0] m_dr;
    int          m_len;
    logic [BL-1:0] m_latch;
    logic [7:0]  m_hold;
    logic        m_tdo, m_oe;

    jtag_scan_display #(.DIGITS(2), .IDCODE(32'h1234_5001)) dut (
        .clk    (clk),
        .reset  (reset),
        .TCK    (TCK),
        .TMS    (TMS),
        .TDI    (TDI),
        .TRST   (TRST),
        .load   (load),
        .d_in   (d_in),
        .y      (y),
        .TDO    (TDO),
        .tdo_oe (tdo_oe)
    );

    always #5 clk = ~clk;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            T_TLR:  return t ? T_TLR  : T_RTI;
            T_RTI:  return t ? T_SDR  : T_RTI;
            T_SDR:  return t ? T_SIR  : T_CDR;
            T_CDR:  return t ? T_E1DR : T_SHDR;
            T_SHDR: return t ? T_E1DR : T_SHDR;
            T_E1DR: return t ? T_UDR  : T_PDR;
            T_PDR:  return t ? T_E2DR : T_PDR;
            T_E2DR: return t ? T_UDR  : T_SHDR;
            T_UDR:  return t ? T_SDR  : T_RTI;
            T_SIR:  return t ? T_TLR  : T_CIR;
            T_CIR:  return t ? T_E1IR : T_SHIR;
            T_SHIR: return t ? T_E1IR : T_SHIR;
            T_E1IR: return t ? T_UIR  : T_PIR;
            T_PIR:  return t ? T_E2IR : T_PIR;
            T_E2IR: return t ? T_UIR  : T_SHIR;
            default: return t ? T_SDR : T_RTI;
        endcase
    endfunction

    function automatic logic [BL-1:0] boundary_of(input logic [7:0] h);
        logic [BL-1:0] b;
        for (int k = 0; k < 2; k++) begin
            b[11*k +: 4]   = h[4*k +: 4];
            b[11*k+4 +: 7] = seg_tab[h[4*k +: 4]];
        end
        return b;
    endfunction

    function automatic logic [13:0] model_y();
        logic [13:0] r;
        for (int k = 0; k < 2; k++)
            r[7*k +: 7] = (m_ir == 2'b00) ? m_latch[11*k+4 +: 7] : seg_tab[m_hold[4*k +: 4]];
        return r;
    endfunction

    task automatic model_reset();
        m_state = T_TLR;
        m_ir    = 2'b10;
        m_irsh  = 2'b00;
        m_dr    = '0;
        m_len   = 32;
        m_latch = '0;
        m_hold  = 8'h00;
        m_tdo   = 1'b0;
        m_oe    = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One full TCK period; model advances by the spec rules at the rise.
    task automatic applyStimulus(input logic tms_v, input logic tdi_v);
        checkOutput("tdo", {31'b0, TDO}, {31'b0, m_tdo});
        valid = 0;
        case (m_state)
            T_CIR:  m_irsh = 2'b01;
            T_SHIR: m_irsh = {tdi_v, m_irsh[1]};
            T_UIR:  m_ir = m_irsh;
            T_CDR: begin
                if (m_ir == 2'b10)      begin m_len = 32; m_dr = 32'h1234_5001; end
                else if (m_ir == 2'b11) begin m_len = 1;  m_dr = 32'h0; end
                else                    begin m_len = BL; m_dr = {10'b0, boundary_of(m_hold)}; end
            end
            T_SHDR: begin
                m_dr = m_dr >> 1;
                m_dr[m_len-1] = tdi_v;
            end
            T_UDR: if (m_ir == 2'b00 || m_ir == 2'b01) m_latch = m_dr[BL-1:0];
            default: ;
        endcase
        m_state = tap_next(m_state, tms_v);
        if (m_state == T_TLR) m_ir = 2'b10;
        @(negedge clk);
        TMS = tms_v;
        TDI = tdi_v;
        TCK = 1'b1;
        repeat (5) @(negedge clk);
        TCK = 1'b0;
        repeat (5) @(negedge clk);
        m_oe  = (m_state == T_SHDR) || (m_state == T_SHIR);
        m_tdo = (m_state == T_SHIR) ? m_irsh[0] : (m_state == T_SHDR) ? m_dr[0] : 1'b0;
        valid = 1;
    endtask

    task automatic shiftBits(input logic [31:0] din, input int n, output logic [31:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            applyStimulus(i == n - 1, din[i]);
        end
    endtask

    task automatic loadIr(input logic [1:0] v, output logic [1:0] cap);
        logic [31:0] d;
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        shiftBits({30'b0, v}, 2, d);
        cap = d[1:0];
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    task automatic scanDr(input logic [31:0] din, input int n, output logic [31:0] dout);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        shiftBits(din, n, dout);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
    endtask

    task automatic doLoad(input logic [7:0] v);
        valid = 0;
        @(negedge clk);
        load   = 1'b1;
        d_in   = v;
        m_hold = v;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        valid = 1;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            checkOutput("y", {18'b0, y}, {18'b0, model_y()});
            checkOutput("tdo_oe", {31'b0, tdo_oe}, {31'b0, m_oe});
        end
    end

    initial begin
        logic [31:0] dout;
        logic [1:0]  cap;

        reset = 1'b1; TCK = 1'b0; TMS = 1'b1; TDI = 1'b0; TRST = 1'b1;
        load = 1'b0; d_in = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_y", {18'b0, y}, 32'h1FBF);
        checkOutput("reset_tdo", {31'b0, TDO}, 32'h0);
        checkOutput("reset_oe", {31'b0, tdo_oe}, 32'h0);
        valid = 1;

        // IDCODE straight out of reset
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("oe_in_shift", {31'b0, tdo_oe}, 32'h1);
        shiftBits(32'h0, 32, dout);
        checkOutput("idcode_stream", dout, 32'h1234_5001);
        checkOutput("oe_after_shift", {31'b0, tdo_oe}, 32'h0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);

        // SAMPLE capture of hold 8'h3A
        doLoad(8'h3A);
        loadIr(2'b01, cap);
        checkOutput("ir_capture", {30'b0, cap}, 32'h1);
        scanDr(32'h0, BL, dout);
        checkOutput("sample_bsr", dout, 32'h0027_9F7A);

        // EXTEST drive of all-ones
        loadIr(2'b00, cap);
        scanDr(32'h003F_FFFF, BL, dout);
        checkOutput("extest_capture", dout, 32'h0027_9F7A);
        checkOutput("extest_y", {18'b0, y}, 32'h3FFF);
        doLoad(8'h00);
        checkOutput("extest_y_after_load", {18'b0, y}, 32'h3FFF);

        // BYPASS one-bit delay
        loadIr(2'b11, cap);
        checkOutput("bypass_y", {18'b0, y}, 32'h1FBF);
        scanDr(32'b1101, 4, dout);
        checkOutput("bypass_stream", dout, 32'b1010);

        // TRST pulse in EXTEST mid Shift-DR
        loadIr(2'b00, cap);
        checkOutput("extest_again_y", {18'b0, y}, 32'h3FFF);
        doLoad(8'h5C);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1);
        valid = 0;
        @(negedge clk) TRST = 1'b0;
        @(negedge clk) TRST = 1'b1;
        m_state = T_TLR; m_ir = 2'b10; m_tdo = 1'b0; m_oe = 1'b0;
        repeat (4) @(negedge clk);
        valid = 1;
        checkOutput("trst_y", {18'b0, y}, 32'h36B9);
        checkOutput("trst_oe", {31'b0, tdo_oe}, 32'h0);
        applyStimulus(0, 0);
        scanDr(32'h0, 32, dout);
        checkOutput("trst_idcode", dout, 32'h1234_5001);

        // Five TMS=1 from Pause-DR
        loadIr(2'b11, cap);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0);
        applyStimulus(0, 0);
        scanDr(32'h0, 32, dout);
        checkOutput("tms5_idcode", dout, 32'h1234_5001);

        // Randomised TAP walk with interleaved loads
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) doLoad(8'($urandom));
            applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom));
        end

        // Reset while load is high
        valid = 0;
        @(negedge clk);
        reset = 1'b1; load = 1'b1; d_in = 8'hE7;
        @(negedge clk);
        checkOutput("reset_load_y", {18'b0, y}, 32'h1FBF);
        checkOutput("reset_load_oe", {31'b0, tdo_oe}, 32'h0);
        reset = 1'b0; load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        valid = 1;
        scanDr(32'h0, 32, dout);
        valid = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
